mem_access: RTL
===============

# mem_access

Memory-stage data-access unit: takes the instruction held in EX/MEM, performs its load or store on the data-memory bus with a req/ack handshake, and drives the MEM/WB register's inputs (`regWAddr`, `result`, `readData`, `pc`). Non-memory instructions pass straight through. Memory operations stall the upstream pipeline until the bus responds. The unit also handles sub-word load extraction and sign extension, store lane steering, and misalignment and timeout errors.

## Interface
- TIMEOUT, 255, maximum BUSY cycles to wait for `dmem_ack` before aborting (1..65535)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset); sampled on rising `clk`
- in_valid  in  1  EX/MEM holds a live instruction
- in_memRead / in_memWrite  in  1 each  load / store (never both)
- in_funct3  in  3  access size/sign
- in_result  in  32  ALU result; byte address for memory ops
- in_wdata  in  32  store data (rs2)
- in_regWAddr  in  5  destination register
- in_pc  in  32  instruction PC
- stall  out  1  hold EX/MEM and earlier stages
- out_regWAddr / out_result / out_readData / out_pc  out  5/32/32/32  to MEM/WB inputs
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  request complete; `dmem_rdata` valid this cycle
- dmem_rdata  in  32  read word
- misalign_err  out  1  one-cycle pulse: misaligned or illegal access dropped
- bus_err  out  1  one-cycle pulse: timeout abort

## Operation
- States: IDLE, BUSY, RESP.
- Bubble means `out_regWAddr`=0, and `out_result`, `out_readData`, `out_pc`=0.
- **IDLE**, with `in_valid`=0: bubble, `stall`=0.
- **IDLE**, valid non-memory instruction: combinational pass-through.
  - `out_*` = `in_*`, with `out_readData`=0.
  - `stall`=0.
- **IDLE**, valid memory op, legal and aligned:
  - Capture addr, lanes, be, we, rd (rd forced to 0 for stores), funct3, pc.
  - `stall`=1 (combinational); outputs bubble.
  - Next state BUSY.
- **Legal funct3 values:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- **Alignment:** H requires addr[0]=0; W requires addr[1:0]=0.
- **IDLE**, valid memory op, illegal funct3 or misaligned:
  - No request; instruction dropped.
  - Bubble, `stall`=0.
  - `misalign_err`=1 in the next cycle only.
- **BUSY:**
  - `dmem_req`=1, other `dmem_*` held stable, `stall`=1, outputs bubble.
  - Timeout counter increments each cycle.
  - On `dmem_ack`=1: capture the extracted read data and go to RESP.
  - If the counter reaches TIMEOUT without an ack: `bus_err` pulse next cycle, captured rd cleared to 0, go to RESP.
- **RESP:**
  - `stall`=0.
  - `out_regWAddr`=captured rd.
  - `out_result`=captured addr.
  - `out_readData`=extracted data (0 for stores and aborts).
  - `out_pc`=captured pc.
  - Inputs are ignored this cycle; next state IDLE.
- **Store steering:** let k = addr[1:0].
  - SB: `dmem_wdata`={4{wdata[7:0]}}, `dmem_be`=4'b0001<<k.
  - SH: `dmem_wdata`={2{wdata[15:0]}}, `dmem_be`=4'b0011<<k.
  - SW: `dmem_wdata`=wdata, `dmem_be`=4'b1111.
- **Load extraction:**
  - Byte = rdata[8k+7:8k]; halfword = rdata[8k+15:8k].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Loads drive `dmem_be` as for stores of the same size.
- `dmem_ack` outside BUSY is ignored.

## Timing
- **Reset:**
  - State IDLE, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0.
  - `dmem_addr`/`dmem_wdata`=0, counter=0, captured registers=0.
  - `misalign_err`=`bus_err`=0.
  - Combinational outputs follow IDLE rules, so `stall` can be 1 during reset if the inputs present a memory op.
- **Memory op latency:** accept at cycle T, request at T+1, RESP at T+1+W+1, where W is the number of wait cycles before ack.
  - Zero-wait case: RESP at T+2, so MEM/WB captures at the end of T+2.
  - Minimum is 3 cycles per memory op.
- `dmem_req` is registered. It rises the cycle after acceptance and falls on the edge after the ack.
- **Timeout:** RESP occurs at T+1+TIMEOUT+1.
- **Reset mid-BUSY:** on the reset edge, `dmem_req` drops and the op is abandoned; a later ack is ignored.
- Back-to-back memory ops: the next op is accepted at the cycle after RESP.

## Test plan
- **LW, zero wait.** LW addr 0x100, ack at the first BUSY cycle, rdata 0xDEADBEEF.
  - `dmem_req` high for 1 cycle; `dmem_be`=1111.
  - RESP at T+2: `out_readData`=0xDEADBEEF, `out_result`=0x100.
  - `stall` high for T and T+1 only.
- **LB/LBU at addr 0x103, rdata 0x80123456.**
  - LB: `out_readData`=0xFFFFFF80.
  - LBU: `out_readData`=0x00000080.
  - `dmem_addr`=0x100.
- **SH at 0x102, wdata 0x1234ABCD, ack after 3 waits.**
  - `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_we`=1, all stable 4 cycles.
  - RESP: `out_regWAddr`=0.
- **LW at 0x102 (misaligned).**
  - No `dmem_req`; `stall`=0; bubble.
  - `misalign_err` pulse one cycle later.
  - Following ADD passes through unchanged.
- **Timeout.** TIMEOUT=4, LW with no ack.
  - `bus_err` pulse; RESP with `out_regWAddr`=0 at T+6.
  - `stall` released at T+6.
- **Reset mid-BUSY.** `reset`=0 during BUSY.
  - Next cycle: IDLE, `dmem_req`=0.
  - A subsequent stray `dmem_ack` produces no output change.

Source files
------------

// File: rtl/mem_access.sv
// Memory-stage data-access unit: performs EX/MEM loads/stores over a req/ack
// data bus, stalls upstream while busy, and drives the MEM/WB register inputs.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_memRead,
  input  logic        in_memWrite,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_regWAddr,
  input  logic [31:0] in_pc,
  output logic        stall,
  output logic [4:0]  out_regWAddr,
  output logic [31:0] out_result,
  output logic [31:0] out_readData,
  output logic [31:0] out_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  // Incoming-instruction decode: legality, alignment and lane steering.
  logic        is_mem, legal_f3, aligned;
  logic [1:0]  k_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path through the case statements can infer a latch.
    is_mem   = in_memRead | in_memWrite;
    k_in     = in_result[1:0];
    be_in    = 4'b0000;
    wdata_in = 32'h0;
    aligned  = 1'b0;
    case (in_funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << k_in;
        wdata_in = {4{in_wdata[7:0]}};
        aligned  = 1'b1;
      end
      2'b01: begin
        be_in    = 4'b0011 << k_in;
        wdata_in = {2{in_wdata[15:0]}};
        aligned  = ~k_in[0];
      end
      2'b10: begin
        be_in    = 4'b1111;
        wdata_in = in_wdata;
        aligned  = (k_in == 2'b00);
      end
      default: ;
    endcase
    if (in_memWrite) legal_f3 = in_funct3 inside {3'b000, 3'b001, 3'b010};
    else             legal_f3 = in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  // Read-data lane extraction using the captured address and access size.
  logic [31:0] shifted, extracted;

  always_comb begin
    shifted = dmem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extracted = {24'h0, shifted[7:0]};
      3'b101:  extracted = {16'h0, shifted[15:0]};
      default: extracted = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    pc_d         = pc_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    stall        = 1'b0;
    out_regWAddr = 5'd0;
    out_result   = 32'h0;
    out_readData = 32'h0;
    out_pc       = 32'h0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_regWAddr = in_regWAddr;
            out_result   = in_result;
            out_pc       = in_pc;
          end else if (legal_f3 && aligned) begin
            stall    = 1'b1;
            addr_d   = in_result;
            be_d     = be_in;
            we_d     = in_memWrite;
            wdata_d  = in_memWrite ? wdata_in : 32'h0;
            rd_d     = in_memWrite ? 5'd0 : in_regWAddr;
            funct3_d = in_funct3;
            pc_d     = in_pc;
            rdata_d  = 32'h0;
            cnt_d    = 16'd0;
            req_d    = 1'b1;
            state_d  = BUSY;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack) begin
          rdata_d = we_q ? 32'h0 : extracted;
          req_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          // Aborted op retires as a bubble-like writeback to x0.
          bus_err_d = 1'b1;
          rd_d      = 5'd0;
          req_d     = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        out_regWAddr = rd_q;
        out_result   = addr_q;
        out_readData = rdata_q;
        out_pc       = pc_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      be_q       <= 4'b0000;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      funct3_q   <= 3'b000;
      pc_q       <= 32'h0;
      rdata_q    <= 32'h0;
      cnt_q      <= 16'd0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      pc_q       <= pc_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = {addr_q[31:2], 2'b00};
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule
